frame_scheduler: RTL and testbench
==================================

# frame_scheduler

- Sequences the VGA pixel datapath once per frame.
- Each frame it erases the three on-screen objects (two autonomous test boxes, one player box), updates their positions, then redraws them.
- It drives the VGA adapter's x/y/colour/plot inputs, one pixel per cycle.
- It owns the frame-rate divider and the debounced player direction input.

## Interface

Parameters:
- FRAME_DIV, 833333 — clock_50 cycles per frame tick (60 Hz).
- SIZE_LOG2, 3 — object side = 2^SIZE_LOG2 pixels (S = 8); N = S*S pixels per object.

Ports:
- clock_50  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- direction  in  3  raw active-low keys: [2] up, [1] right, [0] down.
- x  out  8  pixel column to VGA adapter.
- y  out  7  pixel row to VGA adapter.
- colour  out  3  pixel colour.
- plot  out  1  write strobe: x/y/colour are valid this cycle.
- busy  out  1  high while not in WAIT.
- frame_done  out  1  one-cycle pulse when DRAW completes.
- overrun  out  1  one-cycle pulse when a tick arrives while a tick is already pending.

## Operation

- Screen is 160x120. MAXX = 160-S, MAXY = 120-S.
- Reset values:
  - Positions: T1 = (0,0), T2 = (MAXX,MAXY), P = (76,104).
  - state = WAIT, divider = 0, pending = 0.
  - All outputs 0.
- Divider counts 0..FRAME_DIV-1. On wrap it sets pending; if pending is already set, it pulses overrun.
- States:
  - WAIT: if pending, clear pending and go to ERASE (obj = 0, pix = 0). Otherwise stay.
  - ERASE: drive one pixel per cycle with colour 000 at the current positions.
    - Order: obj 0 (T1), 1 (T2), 2 (P).
    - Per pixel: x = objX + pix[SIZE_LOG2-1:0], y = objY + pix[2*SIZE_LOG2-1:SIZE_LOG2].
    - After the last pixel of obj 2, go to MOVE.
  - MOVE (single cycle, plot = 0):
    - T1.x: becomes 0 if it equals MAXX, else +1.
    - T2.x: becomes MAXX if it equals 0, else -1.
    - P: uses the synchronised direction sampled this cycle; priority up > right > down.
      - up: y = (y ≥ 4) ? y-4 : 0.
      - right: x = (x+4 ≤ MAXX) ? x+4 : MAXX.
      - down: y = (y+4 ≤ MAXY) ? y+4 : MAXY.
      - No key pressed: no change.
  - DRAW: same scan as ERASE using the new positions. Colours: T1 and T2 = 111, P = 100. After the last pixel, pulse frame_done and go to WAIT.
- direction passes through a 2-flop synchroniser. Holding a key moves P one step per frame.
- All arithmetic is done at 9 bits (x) or 8 bits (y) before comparison; no wrap-around escapes the clamp.

## Timing

- x, y, colour, plot, frame_done and overrun are all registered.
- plot is high for exactly 3N consecutive cycles in ERASE, then low for 1 cycle (MOVE), then high for 3N consecutive cycles in DRAW. It is low everywhere else.
- Latency:
  - The divider wraps at edge t.
  - At edge t+1 the FSM enters ERASE.
  - The first plot=1 pixel is visible after edge t+2.
  - frame_done is visible after edge t+2+6N+1.
- A frame occupies 6N+3 cycles; FRAME_DIV must exceed this.
- A tick during ERASE/MOVE/DRAW is held in pending (depth 1). The next frame starts on the cycle after WAIT is re-entered.
- A tick in the same cycle WAIT consumes pending: pending stays set and overrun pulses.
- reset_n low mid-frame: on that edge every register takes its reset value, plot = 0 from the next cycle, and the partial frame is abandoned.

## Test plan

- **Reset and first frame.** Hold reset_n low 3 cycles, then release with FRAME_DIV=1000. Required:
  - plot = 0 for 1000 cycles.
  - Then 192 plot cycles with colour 000, starting at (0,0),(1,0)…(7,0),(0,1).
  - Then 1 idle cycle.
  - Then 192 draw cycles; the first T1 pixel is (1,0) colour 111.
  - frame_done pulses once.
- **T1 wrap.** Force/run until T1.x = 152. The next frame's DRAW T1 pixels start at (0,0).
- **T2 wrap.** T2.x = 0 wraps to 152 in the next frame.
- **Player clamp.**
  - Hold direction = 3'b011 (up) from P = (76,104) for 27 frames: P.y goes 100, 96, … 0 and stays 0.
  - Hold 3'b101 (right) from x = 148: x becomes 152 and stays 152.
- **Priority.** direction = 3'b000 during MOVE → up only: P goes from (76,104) to (76,100).
- **Overrun and reset mid-frame.**
  - FRAME_DIV = 200 (shorter than a frame): pending stays set, the next frame starts 1 cycle after frame_done, and overrun pulses when a second tick arrives while pending is set.
  - Assert reset_n during DRAW: plot = 0 the next cycle, and positions return to (0,0), (152,112), (76,104).

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler: once per frame tick, erases the three on-screen boxes,
// moves them, then redraws them, emitting one VGA pixel per cycle.
//
// Ports:
//   clock_50    system clock
//   reset_n     synchronous active-low reset
//   direction   raw active-low keys: [2] up, [1] right, [0] down
//   x, y        pixel coordinate to the VGA adapter
//   colour      pixel colour
//   plot        x/y/colour valid this cycle
//   busy        high while a frame is being processed
//   frame_done  one-cycle pulse after the last DRAW pixel
//   overrun     one-cycle pulse when a tick arrives with one already pending
module frame_scheduler #(
   parameter int unsigned FRAME_DIV = 833333,
   parameter int unsigned SIZE_LOG2 = 3
) (
   input  logic       clock_50,
   input  logic       reset_n,
   input  logic [2:0] direction,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun
);
   localparam int unsigned SIDE  = 1 << SIZE_LOG2;
   localparam int unsigned PIX_W = 2 * SIZE_LOG2;
   localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int unsigned MAXX  = 160 - SIDE;
   localparam int unsigned MAXY  = 120 - SIDE;
   localparam int unsigned STEP  = 4;

   localparam logic [7:0] P_X0 = 8'd76;
   localparam logic [6:0] P_Y0 = 7'd104;
   localparam logic [6:0] T1_Y = 7'd0;
   localparam logic [6:0] T2_Y = 7'(MAXY);
   localparam logic [2:0] BOX_COLOUR    = 3'b111;
   localparam logic [2:0] PLAYER_COLOUR = 3'b100;

   typedef enum logic [1:0] {S_WAIT, S_ERASE, S_MOVE, S_DRAW} state_t;

   state_t             state, state_next;
   logic [DIV_W-1:0]   div, div_next;
   logic               pending, pending_next;
   logic [1:0]         obj, obj_next;
   logic [PIX_W-1:0]   pix, pix_next;
   logic [7:0]         t1_x, t1_x_next, t2_x, t2_x_next, p_x, p_x_next;
   logic [6:0]         p_y, p_y_next;
   logic [2:0]         sync1, sync2;
   logic [7:0]         x_next;
   logic [6:0]         y_next;
   logic [2:0]         colour_next;
   logic               plot_next, busy_next, frame_done_next, overrun_next;

   logic               tick;
   logic [7:0]         obj_x;
   logic [6:0]         obj_y;
   logic [8:0]         p_x_plus;
   logic [7:0]         p_y_plus;

   assign tick     = (div == DIV_W'(FRAME_DIV - 1));
   // Widened sums so the clamp compare sees any carry out of the screen range
   assign p_x_plus = {1'b0, p_x} + 9'(STEP);
   assign p_y_plus = {1'b0, p_y} + 8'(STEP);

   // State and datapath registers
   always_ff @(posedge clock_50) begin
      if (!reset_n) begin
         state      <= S_WAIT;
         div        <= '0;
         pending    <= 1'b0;
         obj        <= '0;
         pix        <= '0;
         t1_x       <= '0;
         t2_x       <= 8'(MAXX);
         p_x        <= P_X0;
         p_y        <= P_Y0;
         sync1      <= 3'b111;
         sync2      <= 3'b111;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_next;
         div        <= div_next;
         pending    <= pending_next;
         obj        <= obj_next;
         pix        <= pix_next;
         t1_x       <= t1_x_next;
         t2_x       <= t2_x_next;
         p_x        <= p_x_next;
         p_y        <= p_y_next;
         sync1      <= direction;
         sync2      <= sync1;
         x          <= x_next;
         y          <= y_next;
         colour     <= colour_next;
         plot       <= plot_next;
         busy       <= busy_next;
         frame_done <= frame_done_next;
         overrun    <= overrun_next;
      end
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_next      = state;
      div_next        = tick ? '0 : div + DIV_W'(1);
      pending_next    = pending;
      obj_next        = obj;
      pix_next        = pix;
      t1_x_next       = t1_x;
      t2_x_next       = t2_x;
      p_x_next        = p_x;
      p_y_next        = p_y;
      x_next          = x;
      y_next          = y;
      colour_next     = colour;
      plot_next       = 1'b0;
      frame_done_next = 1'b0;
      overrun_next    = 1'b0;

      case (obj)
         2'd0:    begin obj_x = t1_x; obj_y = T1_Y; end
         2'd1:    begin obj_x = t2_x; obj_y = T2_Y; end
         default: begin obj_x = p_x;  obj_y = p_y;  end
      endcase

      case (state)
         S_WAIT: begin
            if (pending) begin
               state_next   = S_ERASE;
               pending_next = 1'b0;
               obj_next     = '0;
               pix_next     = '0;
            end
         end
         S_ERASE: begin
            plot_next   = 1'b1;
            x_next      = obj_x + 8'(pix[SIZE_LOG2-1:0]);
            y_next      = obj_y + 7'(pix[PIX_W-1:SIZE_LOG2]);
            colour_next = 3'b000;
            {obj_next, pix_next} = {obj, pix} + (PIX_W + 2)'(1);
            if (obj == 2'd2 && pix == '1) state_next = S_MOVE;
         end
         S_MOVE: begin
            t1_x_next = (t1_x == 8'(MAXX)) ? 8'd0 : t1_x + 8'd1;
            t2_x_next = (t2_x == 8'd0) ? 8'(MAXX) : t2_x - 8'd1;
            // Keys are active low; up beats right beats down
            if (!sync2[2])
               p_y_next = (p_y >= 7'(STEP)) ? p_y - 7'(STEP) : 7'd0;
            else if (!sync2[1])
               p_x_next = (p_x_plus <= 9'(MAXX)) ? p_x_plus[7:0] : 8'(MAXX);
            else if (!sync2[0])
               p_y_next = (p_y_plus <= 8'(MAXY)) ? p_y_plus[6:0] : 7'(MAXY);
            obj_next   = '0;
            pix_next   = '0;
            state_next = S_DRAW;
         end
         S_DRAW: begin
            // obj wraps to 3 after the last pixel: one closing cycle for frame_done
            if (obj == 2'd3) begin
               frame_done_next = 1'b1;
               state_next      = S_WAIT;
            end else begin
               plot_next   = 1'b1;
               x_next      = obj_x + 8'(pix[SIZE_LOG2-1:0]);
               y_next      = obj_y + 7'(pix[PIX_W-1:SIZE_LOG2]);
               colour_next = (obj == 2'd2) ? PLAYER_COLOUR : BOX_COLOUR;
               {obj_next, pix_next} = {obj, pix} + (PIX_W + 2)'(1);
            end
         end
         default: state_next = S_WAIT;
      endcase

      // A tick in the consuming cycle keeps pending set and reports the overlap
      if (tick) begin
         overrun_next = pending;
         pending_next = 1'b1;
      end

      busy_next = (state_next != S_WAIT);
   end
endmodule

// File: tb/tb_frame_scheduler.sv
`timescale 1ns/1ps
module tb_frame_scheduler;
   localparam int FD0 = 400;
   localparam int FD1 = 200;

   logic       clock_50 = 1'b0;
   logic       reset_n;
   logic [2:0] direction;

   logic [7:0] x_d    [2];
   logic [6:0] y_d    [2];
   logic [2:0] col_d  [2];
   logic       plot_d [2];
   logic       busy_d [2];
   logic       done_d [2];
   logic       over_d [2];

   always #10 clock_50 = ~clock_50;

   frame_scheduler #(.FRAME_DIV(FD0), .SIZE_LOG2(3)) u0 (
      .clock_50(clock_50), .reset_n(reset_n), .direction(direction),
      .x(x_d[0]), .y(y_d[0]), .colour(col_d[0]), .plot(plot_d[0]),
      .busy(busy_d[0]), .frame_done(done_d[0]), .overrun(over_d[0]));

   frame_scheduler #(.FRAME_DIV(FD1), .SIZE_LOG2(3)) u1 (
      .clock_50(clock_50), .reset_n(reset_n), .direction(direction),
      .x(x_d[1]), .y(y_d[1]), .colour(col_d[1]), .plot(plot_d[1]),
      .busy(busy_d[1]), .frame_done(done_d[1]), .overrun(over_d[1]));

   int nvec = 0;
   int nerr = 0;
   bit after_rst = 1'b0;

   // Reference model: each frame is described by its start edge f; the
   // output after edge f+ph follows directly from the frame timeline.
   int e [2];
   int f [2];
   int ph [2];
   int nf [2] = '{0, 0};
   bit pend [2];
   bit mbusy [2];
   int posx [2][3];
   int posy [2][3];
   bit m_plot [2];
   bit m_done [2];
   bit m_over [2];
   int m_x [2];
   int m_y [2];
   int m_col [2];
   logic [2:0] d1, d2;

   always @(posedge clock_50) begin : model
      int  fd, idx, o, p;
      bit  tick, start;
      for (int i = 0; i < 2; i++) begin
         fd = (i == 0) ? FD0 : FD1;
         if (!reset_n) begin
            e[i] = 0; f[i] = -1; ph[i] = -1; pend[i] = 0; mbusy[i] = 0;
            posx[i][0] = 0;   posy[i][0] = 0;
            posx[i][1] = 152; posy[i][1] = 112;
            posx[i][2] = 76;  posy[i][2] = 104;
            m_plot[i] = 0; m_done[i] = 0; m_over[i] = 0;
            m_x[i] = 0; m_y[i] = 0; m_col[i] = 0;
         end else begin
            e[i]++;
            tick  = (e[i] % fd) == 0;
            start = !mbusy[i] && pend[i];
            m_over[i] = tick && pend[i];
            if (tick) pend[i] = 1;
            else if (start) pend[i] = 0;
            if (start) f[i] = e[i];
            ph[i] = (f[i] >= 0) ? e[i] - f[i] : -1;
            m_plot[i] = 0;
            idx = -1;
            if (ph[i] >= 1 && ph[i] <= 192) idx = ph[i] - 1;
            else if (ph[i] >= 194 && ph[i] <= 385) idx = ph[i] - 194;
            if (ph[i] == 193) begin
               nf[i]++;
               posx[i][0] = (posx[i][0] == 152) ? 0 : posx[i][0] + 1;
               posx[i][1] = (posx[i][1] == 0) ? 152 : posx[i][1] - 1;
               if (!d2[2])      posy[i][2] = (posy[i][2] >= 4) ? posy[i][2] - 4 : 0;
               else if (!d2[1]) posx[i][2] = (posx[i][2] + 4 <= 152) ? posx[i][2] + 4 : 152;
               else if (!d2[0]) posy[i][2] = (posy[i][2] + 4 <= 112) ? posy[i][2] + 4 : 112;
            end
            if (idx >= 0) begin
               o = idx / 64;
               p = idx % 64;
               m_plot[i] = 1;
               m_x[i] = posx[i][o] + p % 8;
               m_y[i] = posy[i][o] + p / 8;
               m_col[i] = (ph[i] < 193) ? 0 : ((o == 2) ? 4 : 7);
            end
            m_done[i] = (ph[i] == 386);
            mbusy[i]  = (ph[i] >= 0 && ph[i] <= 385);
         end
      end
      // Keys reach the mover two edges after they are sampled
      if (!reset_n) begin
         d1 = 3'b111; d2 = 3'b111;
      end else begin
         d2 = d1; d1 = direction;
      end
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s u%0d at %0t: got %0d expected %0d", nm, i, $time, act, exp);
      end
   endtask

   always @(negedge clock_50) begin : compare
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            chk("rst_x", i, 32'(x_d[i]), 0);
            chk("rst_y", i, 32'(y_d[i]), 0);
            chk("rst_colour", i, 32'(col_d[i]), 0);
            chk("rst_plot", i, 32'(plot_d[i]), 0);
            chk("rst_busy", i, 32'(busy_d[i]), 0);
            chk("rst_done", i, 32'(done_d[i]), 0);
            chk("rst_overrun", i, 32'(over_d[i]), 0);
         end else begin
            chk("plot", i, 32'(plot_d[i]), 32'(m_plot[i]));
            chk("busy", i, 32'(busy_d[i]), 32'(mbusy[i]));
            chk("frame_done", i, 32'(done_d[i]), 32'(m_done[i]));
            chk("overrun", i, 32'(over_d[i]), 32'(m_over[i]));
            if (m_plot[i]) begin
               chk("x", i, 32'(x_d[i]), 32'(m_x[i]));
               chk("y", i, 32'(y_d[i]), 32'(m_y[i]));
               chk("colour", i, 32'(col_d[i]), 32'(m_col[i]));
            end
         end
      end
      // Hand-computed anchors for the first frame of u0 (tick at edge 400)
      if (reset_n) begin
         case (e[0])
            400: begin chk("lit_idle_plot", 0, 32'(plot_d[0]), 0); chk("lit_idle_busy", 0, 32'(busy_d[0]), 0); end
            401: begin chk("lit_start_busy", 0, 32'(busy_d[0]), 1); chk("lit_start_plot", 0, 32'(plot_d[0]), 0); end
            402: begin
               chk("lit_first_plot", 0, 32'(plot_d[0]), 1);
               chk("lit_first_x", 0, 32'(x_d[0]), 0);
               chk("lit_first_y", 0, 32'(y_d[0]), 0);
               chk("lit_first_colour", 0, 32'(col_d[0]), 0);
            end
            410: begin chk("lit_row1_x", 0, 32'(x_d[0]), 0); chk("lit_row1_y", 0, 32'(y_d[0]), 1); end
            594: chk("lit_move_plot", 0, 32'(plot_d[0]), 0);
            595: begin
               chk("lit_draw_t1_x", 0, 32'(x_d[0]), 1);
               chk("lit_draw_t1_y", 0, 32'(y_d[0]), 0);
               chk("lit_draw_t1_colour", 0, 32'(col_d[0]), 7);
            end
            723: begin
               chk("lit_player_x", 0, 32'(x_d[0]), 76);
               chk("lit_player_y", 0, 32'(y_d[0]), after_rst ? 104 : 100);
               chk("lit_player_colour", 0, 32'(col_d[0]), 4);
            end
            787: begin chk("lit_frame_done", 0, 32'(done_d[0]), 1); chk("lit_done_busy", 0, 32'(busy_d[0]), 0); end
            default: ;
         endcase
         if (e[1] == 587) chk("lit_u1_done", 1, 32'(done_d[1]), 1);
         if (e[1] == 588) chk("lit_u1_restart_busy", 1, 32'(busy_d[1]), 1);
         if (e[1] == 800) chk("lit_u1_overrun", 1, 32'(over_d[1]), 1);
         if (nf[0] == 152 && ph[0] == 194) chk("lit_t1_at_max", 0, 32'(x_d[0]), 152);
         if (nf[0] == 152 && ph[0] == 258) chk("lit_t2_at_zero", 0, 32'(x_d[0]), 0);
         if (nf[0] == 153 && ph[0] == 194) chk("lit_t1_wrap", 0, 32'(x_d[0]), 0);
         if (nf[0] == 153 && ph[0] == 258) chk("lit_t2_wrap", 0, 32'(x_d[0]), 152);
         if (nf[0] == 27 && ph[0] == 322) begin
            chk("lit_up_clamp_y", 0, 32'(y_d[0]), 0);
            chk("lit_up_clamp_x", 0, 32'(x_d[0]), 76);
         end
         if (nf[0] == 52 && ph[0] == 322) begin
            chk("lit_right_clamp_x", 0, 32'(x_d[0]), 152);
            chk("lit_right_clamp_y", 0, 32'(y_d[0]), 0);
         end
         if (nf[0] == 82 && ph[0] == 322) begin
            chk("lit_down_clamp_x", 0, 32'(x_d[0]), 152);
            chk("lit_down_clamp_y", 0, 32'(y_d[0]), 112);
         end
      end
   end

   initial begin : stimulus
      int cyc;
      int nx;
      reset_n   = 1'b0;
      direction = 3'b000;   // all keys pressed: up must win in frame 1
      repeat (3) @(posedge clock_50);
      @(negedge clock_50); #1;
      reset_n = 1'b1;

      // Frames 2..30 up, 31..52 right, 53..82 down, then idle keys
      cyc = 0;
      while (nf[0] < 155 && cyc < 70000) begin
         @(negedge clock_50); #1;
         cyc++;
         if (ph[0] == 386) begin
            nx = nf[0] + 1;
            direction = (nx <= 30) ? 3'b011 : (nx <= 52) ? 3'b101 :
                        (nx <= 82) ? 3'b110 : 3'b111;
         end
      end
      nvec++;
      if (nf[0] < 155) begin
         nerr++;
         $display("FAIL frame_progress: got %0d frames expected 155 within budget", nf[0]);
      end

      // Reset in the middle of DRAW
      cyc = 0;
      while (ph[0] != 250 && cyc < 1000) begin
         @(negedge clock_50); #1;
         cyc++;
      end
      nvec++;
      if (ph[0] != 250) begin
         nerr++;
         $display("FAIL reach_draw: got phase %0d expected 250", ph[0]);
      end
      reset_n   = 1'b0;
      after_rst = 1'b1;
      @(negedge clock_50); #1;
      reset_n = 1'b1;
      repeat (850) @(negedge clock_50);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
